instr_sequencer: RTL

- Program-counter and instruction-decode front end for the 9-bit processor core: drives the instruction ROM address and splits each fetched instruction into the ALU's Op/T/Rs/ImmI/ImmX fields.
- Consumes the ALU's control results on the return path: branch offset, branch sign, reset request and halt request.
- Runs a small RUN/HALT state machine and reports Done plus an executed-instruction count to the testbench/top level.

---
 rtl/instr_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: program counter, RUN/HALT sequencing and instruction-field
// decode for the 9-bit core front end.
module instr_sequencer #(
  parameter int          PC_W   = 10,
  parameter logic [3:0]  OP_BRC = 4'h2,
  parameter logic [3:0]  OP_RST = 4'hF,
  parameter int          CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic [8:0]       InstIn,
  input  logic [3:0]       BrOffset,
  input  logic             BrSign,
  input  logic             AluReset,
  input  logic             AluHalt,
  output logic [PC_W-1:0]  InstAddr,
  output logic [3:0]       Op,
  output logic             T,
  output logic [3:0]       Rs,
  output logic [4:0]       ImmI,
  output logic [3:0]       ImmX,
  output logic             Valid,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [PC_W-1:0]   r_start_addr;
  logic [PC_W-1:0]   w_start_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_br_off;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_is_brc;
  logic              w_rst_req;

  // Decode is a set of pure slices of the ROM word.
  assign Op   = InstIn[8:5];
  assign T    = InstIn[4];
  assign Rs   = InstIn[3:0];
  assign ImmI = InstIn[4:0];
  assign ImmX = InstIn[3:0];

  assign w_is_brc  = (InstIn[8:5] == OP_BRC);
  // The ALU raises its reset/halt request only while executing the reset opcode;
  // qualifying with the decoded opcode keeps a stray request from redirecting the PC.
  assign w_rst_req = AluReset && (InstIn[8:5] == OP_RST);

  assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_br_off  = {{(PC_W-4){1'b0}}, BrOffset};
  // Retired-instruction count saturates rather than wrapping.
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

  assign InstAddr  = r_pc;
  assign InstCount = r_cnt;
  assign Valid     = (r_state == S_RUN) && !Stall;
  assign Done      = (r_state == S_HALT);

  // State, PC, latched entry address and counter registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_start_addr <= '0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_start_addr <= w_start_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  // Next-state and next-PC selection; ALU requests outrank branches in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_start_nxt = r_start_addr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = StartAddr;
          w_start_nxt = StartAddr;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (!Stall) begin
          if (w_rst_req && AluHalt) begin
            w_state_nxt = S_HALT;
            w_cnt_nxt   = w_cnt_inc;
          end else if (w_rst_req) begin
            w_pc_nxt  = r_start_addr;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_is_brc) begin
              w_pc_nxt = BrSign ? (r_pc - w_br_off) : (r_pc + w_br_off);
            end else begin
              w_pc_nxt = w_pc_inc;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
